// File: rtl/udp_tx_framer.sv
// Grants one upstream UDP sender at a time and frames its payload behind an 8-byte UDP header.
// Output bytes trail the accepted input by one cycle; out_ready=0 stalls header and payload alike.
module udp_tx_framer #(
  parameter int GAP_CYCLES  = 12,
  parameter int MAX_PAYLOAD = 1472
) (
  input  logic        tx_clock,
  input  logic        reset_n,
  input  logic        udp_tx_request,
  input  logic [15:0] udp_tx_length,
  input  logic [7:0]  udp_tx_data,
  input  logic [7:0]  port_ID,
  input  logic [15:0] to_port,
  input  logic        out_ready,
  output logic        udp_tx_enable,
  output logic        udp_tx_active,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_abort,
  output logic        len_error,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_HEADER, S_PAYLOAD, S_GAP} state_t;

  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d, src_q, src_d, dst_q, dst_d;
  logic [15:0] pay_cnt_q, pay_cnt_d, gap_cnt_q, gap_cnt_d, frame_cnt_q, frame_cnt_d;
  logic [3:0]  hdr_cnt_q, hdr_cnt_d;
  logic        over_q, over_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, abort_q, abort_d;

  logic        go, started, last_hdr, last_pay;
  logic [15:0] udp_len;
  logic [7:0]  hdr_byte;

  // Oversized frames are drained blind, so they never wait on the MAC.
  assign go       = out_ready | over_q;
  assign started  = (hdr_cnt_q != 4'd0);
  assign last_hdr = (hdr_cnt_q == 4'd7);
  assign last_pay = (pay_cnt_q == len_q - 16'd1);
  assign udp_len  = len_q + 16'd8;

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_cnt_q[2:0])
      3'd0:    hdr_byte = src_q[15:8];
      3'd1:    hdr_byte = src_q[7:0];
      3'd2:    hdr_byte = dst_q[15:8];
      3'd3:    hdr_byte = dst_q[7:0];
      3'd4:    hdr_byte = udp_len[15:8];
      3'd5:    hdr_byte = udp_len[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (udp_tx_request) state_d = S_GRANT;
      S_GRANT:   state_d = S_HEADER;
      S_HEADER: begin
        if (!udp_tx_request) begin
          if (!started || go) state_d = S_GAP;
        end else if (go && last_hdr) begin
          state_d = (len_q == 16'd0) ? S_GAP : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!udp_tx_request) begin
          if (go) state_d = S_GAP;
        end else if (udp_tx_active && last_pay) begin
          state_d = S_GAP;
        end
      end
      S_GAP:     if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    udp_tx_enable = (state_q == S_GRANT);
    len_error     = (state_q == S_GRANT) && (udp_tx_length > MAX_LEN);
    udp_tx_active = (state_q == S_PAYLOAD) && udp_tx_request && go && (pay_cnt_q < len_q);
  end

  always_comb begin
    len_d       = len_q;
    src_d       = src_q;
    dst_d       = dst_q;
    over_d      = over_q;
    hdr_cnt_d   = hdr_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    abort_d     = 1'b0;
    case (state_q)
      S_GRANT: begin
        len_d     = udp_tx_length;
        src_d     = 16'd1024 + {8'd0, port_ID};
        dst_d     = to_port;
        over_d    = (udp_tx_length > MAX_LEN);
        hdr_cnt_d = 4'd0;
        pay_cnt_d = 16'd0;
        gap_cnt_d = 16'd0;
      end
      S_HEADER: begin
        if (!udp_tx_request) begin
          if (started && go) begin
            data_d  = 8'h00;
            valid_d = !over_q;
            eop_d   = !over_q;
            abort_d = !over_q;
          end
        end else if (go) begin
          data_d    = hdr_byte;
          valid_d   = !over_q;
          sop_d     = (hdr_cnt_q == 4'd0) && !over_q;
          eop_d     = last_hdr && (len_q == 16'd0) && !over_q;
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (last_hdr && (len_q == 16'd0) && !over_q) frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      S_PAYLOAD: begin
        if (!udp_tx_request) begin
          if (go) begin
            data_d  = 8'h00;
            valid_d = !over_q;
            eop_d   = !over_q;
            abort_d = !over_q;
          end
        end else if (udp_tx_active) begin
          data_d    = udp_tx_data;
          valid_d   = !over_q;
          eop_d     = last_pay && !over_q;
          pay_cnt_d = pay_cnt_q + 16'd1;
          if (last_pay && !over_q) frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      S_GAP:   gap_cnt_d = gap_cnt_q + 16'd1;
      default: ;
    endcase
  end

  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= 16'd0;
      src_q       <= 16'd0;
      dst_q       <= 16'd0;
      over_q      <= 1'b0;
      hdr_cnt_q   <= 4'd0;
      pay_cnt_q   <= 16'd0;
      gap_cnt_q   <= 16'd0;
      frame_cnt_q <= 16'd0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      len_q       <= len_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      over_q      <= over_d;
      hdr_cnt_q   <= hdr_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      abort_q     <= abort_d;
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_sop     = sop_q;
  assign out_eop     = eop_q;
  assign out_abort   = abort_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: a sender model feeds payload, a byte scoreboard checks the framed stream.
module tb_udp_tx_framer;
  localparam int GAP  = 12;
  localparam int MAXP = 1472;

  logic        tx_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        udp_tx_request = 1'b0;
  logic [15:0] udp_tx_length = 16'd0;
  logic [7:0]  udp_tx_data = 8'd0;
  logic [7:0]  port_ID = 8'd0;
  logic [15:0] to_port = 16'd0;
  logic        out_ready = 1'b0;
  logic        udp_tx_enable, udp_tx_active, out_valid, out_sop, out_eop, out_abort, len_error;
  logic [7:0]  out_data;
  logic [15:0] frame_count;

  udp_tx_framer #(.GAP_CYCLES(GAP), .MAX_PAYLOAD(MAXP)) dut (
    .tx_clock(tx_clock), .reset_n(reset_n), .udp_tx_request(udp_tx_request),
    .udp_tx_length(udp_tx_length), .udp_tx_data(udp_tx_data), .port_ID(port_ID),
    .to_port(to_port), .out_ready(out_ready), .udp_tx_enable(udp_tx_enable),
    .udp_tx_active(udp_tx_active), .out_data(out_data), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .out_abort(out_abort),
    .len_error(len_error), .frame_count(frame_count)
  );

  always #5 tx_clock = ~tx_clock;

  // Scoreboard entries are {abort, eop, sop, data}.
  logic [10:0] sb [$];
  int n_vec = 0, n_err = 0;
  int act_cnt, valid_cnt, run_len, max_run, lerr_cnt, grant_cnt;
  int tick_no = 0, grant_tick = 0, eop_tick = 0, prev_eop;
  int pay_idx = 0, pbase = 0;
  bit eop_seen, over_mode = 1'b0, rand_ready = 1'b0;

  function automatic logic [7:0] pbyte(input int k);
    return 8'((k * 13 + pbase) & 255);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] pid, input logic [15:0] dport, input int len,
                            input int npay, input bit abort);
    logic [15:0] src, l;
    logic [7:0]  h [8];
    src = 16'd1024 + {8'd0, pid};
    l   = 16'(len + 8);
    h[0] = src[15:8]; h[1] = src[7:0]; h[2] = dport[15:8]; h[3] = dport[7:0];
    h[4] = l[15:8];   h[5] = l[7:0];   h[6] = 8'h00;       h[7] = 8'h00;
    for (int i = 0; i < 8; i++) sb.push_back({1'b0, 1'(i == 7 && len == 0), 1'(i == 0), h[i]});
    for (int k = 0; k < npay; k++) sb.push_back({1'b0, 1'(!abort && k == len - 1), 1'b0, pbyte(k)});
    if (abort) sb.push_back({1'b1, 1'b1, 1'b0, 8'h00});
  endtask

  // One clock: observe at the falling edge, then drive just after the rising edge.
  task automatic tick();
    logic [10:0] e;
    bit act;
    @(negedge tx_clock);
    tick_no++;
    if (out_valid) begin
      valid_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (sb.size() == 0) check("sb_has_entry", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        check("byte", 32'({out_abort, out_eop, out_sop, out_data}), 32'(e));
      end
      if (out_eop) begin eop_seen = 1'b1; eop_tick = tick_no; end
    end else run_len = 0;
    if (udp_tx_active) begin
      act_cnt++;
      check("active_needs_ready", 32'(out_ready | over_mode), 32'd1);
    end
    if (udp_tx_enable) begin grant_cnt++; grant_tick = tick_no; end
    if (len_error) lerr_cnt++;
    act = udp_tx_active;
    @(posedge tx_clock);
    #1;
    if (act) begin pay_idx++; udp_tx_data = pbyte(pay_idx); end
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_frame(input int len);
    pay_idx = 0; udp_tx_data = pbyte(0); udp_tx_length = 16'(len);
    act_cnt = 0; valid_cnt = 0; run_len = 0; max_run = 0; lerr_cnt = 0; grant_cnt = 0;
    eop_seen = 1'b0;
    udp_tx_request = 1'b1;
  endtask

  task automatic run_frame(input int len, input int budget);
    bit done;
    done = 1'b0;
    start_frame(len);
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      done = eop_seen || (over_mode && act_cnt == len);
    end
    check("frame_done", 32'(done), 32'd1);
    udp_tx_request = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({udp_tx_enable, udp_tx_active, out_valid, out_sop, out_eop, out_abort,
                len_error, out_data, frame_count});
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge tx_clock);
    #1;
    check("reset_outputs", all_outs(), 32'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) tick();
    check("idle_no_grant", 32'(grant_cnt + act_cnt), 32'd0);

    // Full-size legal frame, ready held high
    port_ID = 8'd11; to_port = 16'd1037; pbase = 3;
    push_frame(8'd11, 16'd1037, 1444, 1444, 1'b0);
    run_frame(1444, 1700);
    check("a_valid_cnt", 32'(valid_cnt), 32'd1452);
    check("a_valid_run", 32'(max_run), 32'd1452);
    check("a_frame_count", 32'(frame_count), 32'd1);
    check("a_len_error", 32'(lerr_cnt), 32'd0);
    check("a_grants", 32'(grant_cnt), 32'd1);
    check("a_sb_drained", 32'(sb.size()), 32'd0);

    // Zero-length payload: header only
    port_ID = 8'd200; to_port = 16'hFFFF; pbase = 0;
    push_frame(8'd200, 16'hFFFF, 0, 0, 1'b0);
    run_frame(0, 100);
    check("z_valid_cnt", 32'(valid_cnt), 32'd8);
    check("z_active", 32'(act_cnt), 32'd0);
    check("z_frame_count", 32'(frame_count), 32'd2);
    check("z_sb_drained", 32'(sb.size()), 32'd0);

    // Random backpressure during a 60-byte payload
    port_ID = 8'd255; to_port = 16'd53; pbase = 77;
    push_frame(8'd255, 16'd53, 60, 60, 1'b0);
    rand_ready = 1'b1;
    run_frame(60, 2000);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    check("r_valid_cnt", 32'(valid_cnt), 32'd68);
    check("r_frame_count", 32'(frame_count), 32'd3);
    check("r_sb_drained", 32'(sb.size()), 32'd0);

    // Oversized frame drained with the MAC not ready
    port_ID = 8'd1; to_port = 16'd7; pbase = 5;
    over_mode = 1'b1;
    out_ready = 1'b0;
    run_frame(2000, 2500);
    check("o_len_error", 32'(lerr_cnt), 32'd1);
    check("o_grants", 32'(grant_cnt), 32'd1);
    check("o_active", 32'(act_cnt), 32'd2000);
    check("o_valid_cnt", 32'(valid_cnt), 32'd0);
    check("o_frame_count", 32'(frame_count), 32'd3);
    out_ready = 1'b1;
    repeat (GAP + 2) tick();
    over_mode = 1'b0;

    // Legal frame after the oversized one
    port_ID = 8'd2; to_port = 16'd80; pbase = 17;
    push_frame(8'd2, 16'd80, 5, 5, 1'b0);
    run_frame(5, 200);
    check("l_valid_cnt", 32'(valid_cnt), 32'd13);
    check("l_len_error", 32'(lerr_cnt), 32'd0);
    check("l_frame_count", 32'(frame_count), 32'd4);

    // Request dropped after 10 payload bytes
    port_ID = 8'd9; to_port = 16'd443; pbase = 9;
    push_frame(8'd9, 16'd443, 40, 10, 1'b1);
    start_frame(40);
    for (int c = 0; c < 200 && act_cnt < 10; c++) tick();
    udp_tx_request = 1'b0;
    for (int c = 0; c < 50 && !eop_seen; c++) tick();
    check("ab_eop_seen", 32'(eop_seen), 32'd1);
    check("ab_active", 32'(act_cnt), 32'd10);
    check("ab_valid_cnt", 32'(valid_cnt), 32'd19);
    check("ab_frame_count", 32'(frame_count), 32'd4);
    check("ab_sb_drained", 32'(sb.size()), 32'd0);
    prev_eop = eop_tick;
    port_ID = 8'd3; to_port = 16'd9000; pbase = 21;
    push_frame(8'd3, 16'd9000, 3, 3, 1'b0);
    run_frame(3, 100);
    check("ab_gap_to_grant", 32'(grant_tick - prev_eop), 32'(GAP + 1));
    check("ab_next_count", 32'(frame_count), 32'd5);

    // Reset mid-payload
    port_ID = 8'd50; to_port = 16'd60; pbase = 33;
    push_frame(8'd50, 16'd60, 100, 100, 1'b0);
    start_frame(100);
    for (int c = 0; c < 200 && act_cnt < 20; c++) tick();
    check("rs_reached_payload", 32'(act_cnt), 32'd20);
    reset_n = 1'b0;
    #1;
    check("rs_outputs_zero", all_outs(), 32'd0);
    sb.delete();
    udp_tx_request = 1'b0;
    repeat (2) @(posedge tx_clock);
    #1;
    reset_n = 1'b1;
    port_ID = 8'd51; to_port = 16'd61; pbase = 44;
    push_frame(8'd51, 16'd61, 4, 4, 1'b0);
    run_frame(4, 200);
    check("rs_valid_cnt", 32'(valid_cnt), 32'd12);
    check("rs_frame_count", 32'(frame_count), 32'd1);
    check("rs_sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
